correlator_frame: RTL and testbench

- Parametrised N-input integrating correlator with framed byte-serial readout; successor to the fixed 8-input, 16-bit pulse-counter correlator array.
- Accumulates all cross products (i<j) plus per-input auto-power (x_i squared) over a programmable number of sample beats.
- Double-buffers each completed frame into a snapshot and streams it out as bytes over a valid/ready handshake toward the UART TX path.
- Sits between the per-input ADC deserialisers and the host transmitter.

---
 rtl/correlator_pkg.sv | 31 +++
 rtl/correlator_frame_if.sv | 19 +
 rtl/corr_accumulator.sv | 40 ++++
 rtl/correlator_frame.sv | 193 +++++++++++++++++++
 tb/tb_correlator_frame.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/correlator_pkg.sv
// correlator_pkg: shared sizing helpers, header bytes and serializer states
// for the framed N-input integrating correlator.
package correlator_pkg;

  localparam logic [7:0] HDR0 = 8'hA5;
  localparam logic [7:0] HDR1 = 8'h5A;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_SEND
  } ser_state_t;

  function automatic int num_pairs(int n);
    return n * (n - 1) / 2;
  endfunction

  function automatic int num_words(int n);
    return num_pairs(n) + n;
  endfunction

  function automatic int bytes_per_word(int aw);
    return (aw + 7) / 8;
  endfunction

  // Lexicographic index of cross pair (i,j), i<j.
  function automatic int pair_idx(int i, int j, int n);
    return i * n - i * (i + 1) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/correlator_frame_if.sv
// correlator_frame_if: byte stream toward the UART TX path.
// Ports: out_data/out_valid from master, out_ready from slave.
interface correlator_frame_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/corr_accumulator.sv
// corr_accumulator: one saturating correlation word with frame snapshot.
// Ports: clk, reset_n, clr, add_en, frame_end, snap_ld, prod in; snap out.
module corr_accumulator #(
  parameter int PW = 16,
  parameter int AW = 24
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          add_en,
  input  logic          frame_end,
  input  logic          snap_ld,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] snap
);

  logic [AW-1:0] acc;
  logic [AW:0]   sum;
  logic [AW-1:0] sat;

  always_comb begin
    sum = {1'b0, acc} + (AW+1)'(prod);
    sat = sum[AW] ? '1 : sum[AW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc  <= '0;
      snap <= '0;
    end else begin
      if (clr)
        acc <= '0;
      else if (add_en)
        acc <= frame_end ? '0 : sat;
      if (snap_ld)
        snap <= sat;
    end
  end

endmodule

// File: rtl/correlator_frame.sv
// correlator_frame: N-input cross/auto correlator, framed byte readout.
// Ports: clk, reset_n, enable, sample_valid, samples, integ_len in;
// tx (out_data/out_valid/out_ready), busy, overrun.
// Option: CORRELATOR_FRAME_HEADER_EN adds A5,5A,frame-count header.
module correlator_frame
  import correlator_pkg::*;
#(
  parameter int NUM_INPUTS   = 8,
  parameter int SAMPLE_WIDTH = 8,
  parameter int ACC_WIDTH    = 24,
  parameter int INTEG_WIDTH  = 32
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               sample_valid,
  input  logic [NUM_INPUTS*SAMPLE_WIDTH-1:0] samples,
  input  logic [INTEG_WIDTH-1:0]             integ_len,
  correlator_frame_if.master                 tx,
  output logic                               busy,
  output logic                               overrun
);

  localparam int NP    = num_pairs(NUM_INPUTS);
  localparam int NW    = num_words(NUM_INPUTS);
  localparam int BPW   = bytes_per_word(ACC_WIDTH);
  localparam int PW    = 2 * SAMPLE_WIDTH;
  localparam int TOTAL = NW * BPW;
  localparam int IW    = $clog2(TOTAL);

  logic [SAMPLE_WIDTH-1:0] x [NUM_INPUTS];
  logic [PW-1:0]           prod_d [NW];
  logic [PW-1:0]           prod_q [NW];
  logic [ACC_WIDTH-1:0]    snap [NW];
  logic [7:0]              stream_b [TOTAL];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_i
    assign x[i] = samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
    assign prod_d[NP+i] = PW'(x[i]) * PW'(x[i]);
    for (genvar j = i + 1; j < NUM_INPUTS; j++) begin : g_j
      assign prod_d[pair_idx(i, j, NUM_INPUTS)] =
        PW'(x[i]) * PW'(x[j]);
    end
  end

  logic [INTEG_WIDTH-1:0] beat_cnt;
  logic [INTEG_WIDTH-1:0] len_q;
  logic [INTEG_WIDTH-1:0] len_eff;
  logic                   last_beat;
  logic                   s1_valid;
  logic                   s1_last;

  // First beat of a frame sees integ_len live; later beats use the latch.
  always_comb begin
    len_eff = len_q;
    if (beat_cnt == '0)
      len_eff = (integ_len == '0) ? INTEG_WIDTH'(1) : integ_len;
    last_beat = (beat_cnt == len_eff - INTEG_WIDTH'(1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt <= '0;
      len_q    <= INTEG_WIDTH'(1);
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int k = 0; k < NW; k++)
        prod_q[k] <= '0;
    end else if (!enable) begin
      beat_cnt <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        s1_last <= last_beat;
        for (int k = 0; k < NW; k++)
          prod_q[k] <= prod_d[k];
        if (beat_cnt == '0)
          len_q <= len_eff;
        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  ser_state_t state;
  logic [IW-1:0] idx;
  logic add_en, frame_end, snap_ld, clr;

  assign clr       = !enable;
  assign add_en    = enable && s1_valid;
  assign frame_end = add_en && s1_last;
  assign snap_ld   = frame_end && (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  for (genvar w = 0; w < NW; w++) begin : g_w
    logic [BPW*8-1:0] pad;
    corr_accumulator #(
      .PW(PW),
      .AW(ACC_WIDTH)
    ) u_acc (
      .clk       (clk),
      .reset_n   (reset_n),
      .clr       (clr),
      .add_en    (add_en),
      .frame_end (frame_end),
      .snap_ld   (snap_ld),
      .prod      (prod_q[w]),
      .snap      (snap[w])
    );
    assign pad = (BPW*8)'(snap[w]);
    for (genvar b = 0; b < BPW; b++) begin : g_b
      assign stream_b[w*BPW+b] = pad[b*8 +: 8];
    end
  end

`ifdef CORRELATOR_FRAME_HEADER_EN
  logic [7:0] fcnt;
  logic [7:0] hdr_id;

  always_comb begin
    tx.out_data = stream_b[idx];
    if (state == S_HEADER) begin
      unique case (1'b1)
        (idx == IW'(0)): tx.out_data = HDR0;
        (idx == IW'(1)): tx.out_data = HDR1;
        default:         tx.out_data = hdr_id;
      endcase
    end
  end
`else
  assign tx.out_data = stream_b[idx];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      tx.out_valid <= 1'b0;
      overrun      <= 1'b0;
`ifdef CORRELATOR_FRAME_HEADER_EN
      fcnt         <= '0;
      hdr_id       <= '0;
`endif
    end else begin
      if (!enable)
        overrun <= 1'b0;
      else if (frame_end && state != S_IDLE)
        overrun <= 1'b1;
`ifdef CORRELATOR_FRAME_HEADER_EN
      if (frame_end)
        fcnt <= fcnt + 8'd1;
`endif
      unique case (state)
        S_IDLE: begin
          if (snap_ld) begin
            tx.out_valid <= 1'b1;
            idx          <= '0;
`ifdef CORRELATOR_FRAME_HEADER_EN
            state        <= S_HEADER;
            hdr_id       <= fcnt;
`else
            state        <= S_SEND;
`endif
          end
        end
        S_HEADER: begin
          if (tx.out_ready) begin
            if (idx == IW'(2)) begin
              state <= S_SEND;
              idx   <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        S_SEND: begin
          if (tx.out_ready) begin
            if (idx == IW'(TOTAL-1)) begin
              state        <= S_IDLE;
              tx.out_valid <= 1'b0;
              idx          <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_correlator_frame.sv
// tb_correlator_frame: scoreboard bench for correlator_frame, N=3,
// 8-bit samples, 16-bit words, with a sum-of-products reference model.
module tb_correlator_frame;

  localparam int N  = 3;
  localparam int NW = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic [23:0] samples = '0;
  logic [31:0] integ_len = 32'd1;
  logic        busy;
  logic        overrun;

  correlator_frame_if bus ();

  correlator_frame #(
    .NUM_INPUTS  (3),
    .SAMPLE_WIDTH(8),
    .ACC_WIDTH   (16),
    .INTEG_WIDTH (32)
  ) u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .sample_valid(sample_valid),
    .samples     (samples),
    .integ_len   (integ_len),
    .tx          (bus),
    .busy        (busy),
    .overrun     (overrun)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];

  longint m_sum [NW];
  int     m_cnt = 0;
  int     m_len = 1;
  logic [7:0] m_fcnt = 8'd0;

  bit rand_ready = 1'b0;
  bit ready_force = 1'b1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic void m_clear();
    for (int k = 0; k < NW; k++) m_sum[k] = 0;
    m_cnt = 0;
  endfunction

  function automatic void m_frame(input bit accept);
    logic [15:0] v;
    if (accept) begin
`ifdef CORRELATOR_FRAME_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h5A);
      exp_q.push_back(m_fcnt);
`endif
      for (int w = 0; w < NW; w++) begin
        v = (m_sum[w] > 65535) ? 16'hFFFF : 16'(m_sum[w]);
        exp_q.push_back(v[7:0]);
        exp_q.push_back(v[15:8]);
      end
    end
    m_fcnt = m_fcnt + 8'd1;
    m_clear();
  endfunction

  function automatic void m_beat(input int xv [N], input bit accept);
    int k;
    if (m_cnt == 0) m_len = (integ_len == 0) ? 1 : int'(integ_len);
    k = 0;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++) begin
        m_sum[k] += longint'(xv[i] * xv[j]);
        k++;
      end
    for (int i = 0; i < N; i++)
      m_sum[N*(N-1)/2 + i] += longint'(xv[i] * xv[i]);
    m_cnt++;
    if (m_cnt == m_len) m_frame(accept);
  endfunction

  task automatic beat(input int a, input int b, input int c,
                      input bit accept = 1'b1);
    int xv [N];
    xv[0] = a; xv[1] = b; xv[2] = c;
    samples = {8'(c), 8'(b), 8'(a)};
    sample_valid = 1'b1;
    m_beat(xv, accept);
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: left %0d bytes, busy %0b",
               exp_q.size(), busy);
      exp_q.delete();
    end
    idle(2);
  endtask

  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2 bus.out_ready = rand_ready ? 1'($urandom % 2) : ready_force;
    end
  end

  initial begin : monitor
    bit hold_pending;
    logic [7:0] hold_data, exp;
    hold_pending = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", 32'(bus.out_valid), 32'd1);
          check("hold_data", 32'(bus.out_data), 32'(hold_data));
        end
        hold_pending = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_byte: got %0h, want none",
                     bus.out_data);
          end else begin
            exp = exp_q.pop_front();
            check("stream_byte", 32'(bus.out_data), 32'(exp));
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    m_clear();
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    enable = 1'b1;
    idle(2);

    // basic frame, ready held high
    integ_len = 32'd4;
    repeat (4) beat(2, 2, 2);
    drain();
    check("basic_busy", 32'(busy), 32'd0);

    integ_len = 32'd1;
    beat(1, 2, 3);
    drain();

    integ_len = 32'd2;
    repeat (2) beat(255, 255, 255);
    drain();

    // random frames with random gaps and backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 8; f++) begin
      integ_len = 32'($urandom_range(1, 5));
      for (int b = 0; b < int'(integ_len); b++) begin
        if ($urandom % 3 == 0) idle(1);
        beat(int'($urandom % 256), int'($urandom % 256),
             int'($urandom % 256));
      end
      drain();
    end

    // integ_len = 0 behaves as single-beat frames
    integ_len = 32'd0;
    beat(5, 6, 7);
    drain();
    beat(9, 10, 11);
    drain();

    // mid-frame length change takes effect next frame
    integ_len = 32'd4;
    beat(1, 1, 1);
    beat(2, 3, 4);
    integ_len = 32'd2;
    beat(5, 6, 7);
    beat(8, 9, 10);
    drain();
    beat(3, 3, 3);
    beat(4, 4, 4);
    drain();

    // backpressure with overrunning single-beat frames
    rand_ready = 1'b0;
    ready_force = 1'b0;
    integ_len = 32'd1;
    beat(9, 8, 7, 1'b1);
    repeat (4) beat(1, 2, 3, 1'b0);
    idle(20);
    check("ovr_valid", 32'(bus.out_valid), 32'd1);
    check("ovr_first_byte", 32'(bus.out_data), 32'(exp_q[0]));
    check("ovr_flag", 32'(overrun), 32'd1);
    rand_ready = 1'b1;
    drain();
    check("ovr_sticky", 32'(overrun), 32'd1);
    enable = 1'b0;
    idle(1);
    check("ovr_cleared", 32'(overrun), 32'd0);
    enable = 1'b1;
    idle(1);

    // enable drop discards a partial frame
    integ_len = 32'd3;
    beat(50, 60, 70);
    beat(20, 30, 40);
    enable = 1'b0;
    m_clear();
    idle(2);
    enable = 1'b1;
    integ_len = 32'd2;
    beat(7, 8, 9);
    beat(1, 2, 3);
    drain();

    // async reset during SEND
    rand_ready = 1'b0;
    ready_force = 1'b0;
    integ_len = 32'd1;
    beat(3, 4, 5);
    idle(3);
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    integ_len = 32'd2;
    beat(7, 7, 7);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    m_clear();
    m_fcnt = 8'd0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    rand_ready = 1'b1;
    idle(1);
    beat(1, 1, 1);
    beat(2, 2, 2);
    drain();
    check("post_rst_ovr", 32'(overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
